// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph table, FSM state type and BCD sizing helper for the 7-segment driver
package seg7_pkg;

    localparam logic [6:0] SEG_DASH  = 7'h01;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Logical segment codes, bit6 = A .. bit0 = G, 1 = lit
    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} conv_state_t;

    // Number of decimal digits needed to hold 2^width-1 (width up to 32)
    function automatic int bcd_digits(input int width);
        longint unsigned max_val;
        longint unsigned lim;
        int              n;
        max_val = (64'd1 << width) - 64'd1;
        lim     = 64'd10;
        n       = 1;
        for (int i = 1; i < 10; i++) begin
            if (max_val >= lim) begin
                n = i + 1;
            end
            lim = lim * 64'd10;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to BCD converter, one bit per cycle
module bin_to_bcd_seq
    import seg7_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int OUT_DIGITS = 4
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Start,
    input  logic [WIDTH-1:0]        i_Bin,
    output logic                    o_Busy,
    output logic                    o_Done,
    output logic [4*OUT_DIGITS-1:0] o_Digits,
    output logic                    o_Overflow
);

    localparam int BCD_DIGITS = bcd_digits(WIDTH);
    localparam int BCDW       = 4 * BCD_DIGITS;
    localparam int EXT_DIGITS = (BCD_DIGITS > OUT_DIGITS) ? BCD_DIGITS : OUT_DIGITS;
    localparam int CW         = $clog2(WIDTH);

    logic [WIDTH-1:0]        r_bin;
    logic [BCDW-1:0]         r_bcd;
    logic [BCDW-1:0]         w_adj;
    logic [CW-1:0]           r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic [4*EXT_DIGITS-1:0] w_ext;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_Start && !r_busy) begin
                // First shift is folded into the load: BCD starts at zero so no add-3 applies
                r_bcd  <= {{(BCDW-1){1'b0}}, i_Bin[WIDTH-1]};
                r_bin  <= i_Bin << 1;
                r_cnt  <= CW'(WIDTH - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                r_cnt          <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_ext            = '0;
        w_ext[BCDW-1:0]  = r_bcd;
        o_Overflow       = 1'b0;
        for (int i = OUT_DIGITS; i < EXT_DIGITS; i++) begin
            o_Overflow = o_Overflow | (|w_ext[4*i +: 4]);
        end
    end

    assign o_Digits = w_ext[4*OUT_DIGITS-1:0];
    assign o_Busy   = r_busy;
    assign o_Done   = r_done;

endmodule

// File: rtl/multi_digit_7seg_driver.sv
// rtl/multi_digit_7seg_driver.sv - time-multiplexed seven-segment driver with hex or decimal rendering
module multi_digit_7seg_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIN_WIDTH      = 16,
    parameter int DECIMAL        = 0,
    parameter int SCAN_DIV       = 25000,
    parameter int BLANK_LEADING  = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Valid,
    input  logic [DIN_WIDTH-1:0]  i_Value,
    output logic                  o_Ready,
    output logic                  o_Overflow,
    output logic [6:0]            o_Segment,
    output logic [NUM_DIGITS-1:0] o_Digit_En
);

    localparam int DIGW = 4 * NUM_DIGITS;
    localparam int EXTW = (DIN_WIDTH > DIGW) ? DIN_WIDTH : DIGW;
    localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0]            SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_XOR = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    conv_state_t           r_state;
    conv_state_t           w_next;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_commit;
    logic [EXTW-1:0]       w_val_ext;
    logic [DIGW-1:0]       w_hex_digits;
    logic                  w_hex_ovf;
    logic [DIGW-1:0]       w_conv_digits;
    logic                  w_conv_ovf;
    logic                  w_conv_busy;
    logic                  w_conv_done;
    logic [DIGW-1:0]       r_disp;
    logic                  r_ovf;
    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [3:0]            w_digit;
    logic [NUM_DIGITS-1:0] w_zero_from;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [6:0]            w_seg;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;

    assign o_Ready  = (DECIMAL == 0) || ((r_state == IDLE) && !w_conv_busy);
    assign w_accept = i_Valid && o_Ready;

    assign w_val_ext    = EXTW'(i_Value);
    assign w_hex_digits = w_val_ext[DIGW-1:0];
    assign w_hex_ovf    = |(w_val_ext >> DIGW);

    generate
        if (DECIMAL != 0) begin : g_dec
            bin_to_bcd_seq #(
                .WIDTH      (DIN_WIDTH),
                .OUT_DIGITS (NUM_DIGITS)
            ) u_bcd (
                .i_Clk      (i_Clk),
                .i_Rst      (i_Rst),
                .i_Start    (w_start),
                .i_Bin      (i_Value),
                .o_Busy     (w_conv_busy),
                .o_Done     (w_conv_done),
                .o_Digits   (w_conv_digits),
                .o_Overflow (w_conv_ovf)
            );
        end else begin : g_hex
            assign w_conv_busy   = 1'b0;
            assign w_conv_done   = 1'b0;
            assign w_conv_digits = '0;
            assign w_conv_ovf    = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = w_accept && (DECIMAL != 0);
                if (w_start) begin
                    w_next = CONVERT;
                end
            end
            CONVERT: begin
                if (w_conv_done) begin
                    w_next = COMMIT;
                end
            end
            COMMIT: begin
                w_commit = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else if ((DECIMAL == 0) && w_accept) begin
            r_disp <= w_hex_digits;
            r_ovf  <= w_hex_ovf;
        end else if (w_commit) begin
            r_disp <= w_conv_digits;
            r_ovf  <= w_conv_ovf;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == PW'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // w_zero_from[i] is set when digit i and every digit above it are zero
    always_comb begin
        logic w_acc;
        w_acc       = 1'b1;
        w_zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_acc          = w_acc && (r_disp[4*i +: 4] == 4'd0);
            w_zero_from[i] = w_acc;
        end
    end

    always_comb begin
        w_digit  = r_disp[4*r_idx +: 4];
        w_onehot = '0;
        w_onehot[r_idx] = 1'b1;
        if (r_ovf) begin
            w_seg = SEG_DASH;
        end else if ((BLANK_LEADING != 0) && (r_idx != '0) && w_zero_from[r_idx]) begin
            w_seg = SEG_BLANK;
        end else begin
            w_seg = GLYPH[w_digit];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_seg <= SEG_BLANK ^ SEG_XOR;
            r_dig <= DIG_XOR;
        end else begin
            r_seg <= w_seg ^ SEG_XOR;
            r_dig <= w_onehot ^ DIG_XOR;
        end
    end

    assign o_Segment  = r_seg;
    assign o_Digit_En = r_dig;
    assign o_Overflow = r_ovf;

endmodule

// File: tb/tb_multi_digit_7seg_driver.sv
// tb/tb_multi_digit_7seg_driver.sv - self-checking bench for hex, unblanked hex and decimal driver instances
module tb_multi_digit_7seg_driver;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SD = 4;
    localparam bit K_DEC   [3] = '{1'b0, 1'b0, 1'b1};
    localparam bit K_BLANK [3] = '{1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         h_valid;
    logic [W-1:0] h_value;
    logic         d_valid;
    logic [W-1:0] d_value;
    logic         rdy [3];
    logic         ovf [3];
    logic [6:0]   seg [3];
    logic [N-1:0] den [3];

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] glyph [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };
    logic [3:0] den_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    multi_digit_7seg_driver #(.NUM_DIGITS(N), .DIN_WIDTH(W), .DECIMAL(0), .SCAN_DIV(SD),
        .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_hex (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(h_valid), .i_Value(h_value),
        .o_Ready(rdy[0]), .o_Overflow(ovf[0]), .o_Segment(seg[0]), .o_Digit_En(den[0]));

    multi_digit_7seg_driver #(.NUM_DIGITS(N), .DIN_WIDTH(W), .DECIMAL(0), .SCAN_DIV(SD),
        .BLANK_LEADING(0), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_hex_nb (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(h_valid), .i_Value(h_value),
        .o_Ready(rdy[1]), .o_Overflow(ovf[1]), .o_Segment(seg[1]), .o_Digit_En(den[1]));

    multi_digit_7seg_driver #(.NUM_DIGITS(N), .DIN_WIDTH(W), .DECIMAL(1), .SCAN_DIV(SD),
        .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_dec (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(d_valid), .i_Value(d_value),
        .o_Ready(rdy[2]), .o_Overflow(ovf[2]), .o_Segment(seg[2]), .o_Digit_En(den[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_ovf(input int unsigned v, input bit dec);
        return dec ? (v >= 10000) : ((v >> (4 * N)) != 0);
    endfunction

    // Active-low pin pattern a digit position must show for value v
    function automatic logic [6:0] model_seg(input int unsigned v, input bit dec, input bit blnk, input int pos);
        int unsigned dig [N];
        int unsigned scale;
        bit          upper_zero;
        logic [6:0]  lit;
        scale = 1;
        for (int i = 0; i < N; i++) begin
            dig[i] = dec ? (v / scale) % 10 : (v >> (4 * i)) & 15;
            scale  = scale * 10;
        end
        upper_zero = 1'b1;
        for (int i = pos; i < N; i++) begin
            if (dig[i] != 0) upper_zero = 1'b0;
        end
        if (model_ovf(v, dec))                   lit = 7'h01;
        else if (blnk && pos > 0 && upper_zero)  lit = 7'h00;
        else                                     lit = glyph[dig[pos]];
        return ~lit;
    endfunction

    bit           started = 1'b0;
    int unsigned  cyc = 0;
    int unsigned  m_val  [3] = '{0, 0, 0};
    int unsigned  m_pend [3] = '{0, 0, 0};
    int           m_cnt  [3] = '{0, 0, 0};
    bit           p_rst = 1'b0, p_hv = 1'b0, p_dv = 1'b0;
    logic [W-1:0] p_hval = '0, p_dval = '0;

    // Inputs change only just after a rising edge, so the values seen here are those the next edge samples
    always @(negedge clk) begin
        logic [6:0]   e_seg;
        logic [N-1:0] e_den;
        int           pos;
        bit           v_in;
        int unsigned  x_in;
        pos = (cyc / SD) % N;
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                if (p_rst) begin
                    e_seg = 7'h7F;
                    e_den = '1;
                end else begin
                    e_seg = model_seg(m_val[k], K_DEC[k], K_BLANK[k], pos);
                    e_den = ~(N'(1) << pos);
                end
                chk($sformatf("seg%0d", k), 32'(seg[k]), 32'(e_seg));
                chk($sformatf("den%0d", k), 32'(den[k]), 32'(e_den));
            end
        end
        if (p_rst) begin
            started = 1'b1;
            cyc     = 0;
            for (int k = 0; k < 3; k++) begin
                m_val[k] = 0;
                m_cnt[k] = 0;
            end
        end else if (started) begin
            cyc++;
            for (int k = 0; k < 3; k++) begin
                v_in = (k == 2) ? p_dv : p_hv;
                x_in = (k == 2) ? p_dval : p_hval;
                if (!K_DEC[k]) begin
                    if (v_in) m_val[k] = x_in;
                end else if (m_cnt[k] > 0) begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) m_val[k] = m_pend[k];
                end else if (v_in) begin
                    m_cnt[k]  = W + 1;
                    m_pend[k] = x_in;
                end
            end
        end
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(m_cnt[k] == 0));
                chk($sformatf("ovf%0d", k), 32'(ovf[k]), 32'(model_ovf(m_val[k], K_DEC[k])));
            end
        end
        p_rst  = rst;
        p_hv   = h_valid;
        p_hval = h_value;
        p_dv   = d_valid;
        p_dval = d_value;
    end

    task automatic expect_digit(input int k, input int pos, input logic [6:0] exp, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #3;
            if (den[k] === ~(4'(1) << pos)) begin
                found = 1'b1;
                chk(name, 32'(seg[k]), 32'(exp));
            end
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: digit %0d never enabled, got none expected %h", name, pos, exp);
        end
    endtask

    task automatic dec_send(input logic [W-1:0] v, input string name);
        bit done;
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_value = v;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (rdy[2] === 1'b1) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: ready never returned, got 0 expected 1", name);
        end
    endtask

    initial begin
        int  lowcnt;
        bit  seen_high;
        rst     = 1'b1;
        h_valid = 1'b0;
        h_value = '0;
        d_valid = 1'b0;
        d_value = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and scan sequence
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #3;
            if (j == 0) begin
                chk("rst_ready", 32'(rdy[2]), 32'd1);
                chk("rst_ovf", 32'(ovf[2]), 32'd0);
            end
            chk($sformatf("scan_den_%0d", j), 32'(den[0]), 32'(den_seq[j / 4]));
            chk($sformatf("scan_seg_%0d", j), 32'(seg[0]), ((j / 4) % 4 == 0) ? 32'h01 : 32'h7F);
            chk($sformatf("scan_nb_%0d", j), 32'(seg[1]), 32'h01);
        end

        // Hex rendering of 0x00B3
        @(posedge clk);
        #1;
        h_valid = 1'b1;
        h_value = 16'h00B3;
        @(posedge clk);
        #1;
        h_valid = 1'b0;
        expect_digit(0, 0, 7'h06, "hex_d0");
        expect_digit(0, 1, 7'h60, "hex_d1");
        expect_digit(0, 2, 7'h7F, "hex_d2");
        expect_digit(0, 3, 7'h7F, "hex_d3");
        expect_digit(1, 2, 7'h01, "hexnb_d2");
        expect_digit(1, 3, 7'h01, "hexnb_d3");

        // Decimal 1234 with a dropped value during conversion
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_value = 16'd1234;
        @(posedge clk);
        #1;
        d_valid   = 1'b0;
        lowcnt    = 0;
        seen_high = 1'b0;
        for (int i = 0; i < 40 && !seen_high; i++) begin
            if (rdy[2] === 1'b0) lowcnt++;
            else seen_high = 1'b1;
            if (i == 4) begin
                d_valid = 1'b1;
                d_value = 16'd9;
            end
            if (i == 5) d_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("dec_ready_low_cycles", 32'(lowcnt), 32'd17);
        expect_digit(2, 0, 7'h4C, "dec1234_d0");
        expect_digit(2, 1, 7'h06, "dec1234_d1");
        expect_digit(2, 2, 7'h12, "dec1234_d2");
        expect_digit(2, 3, 7'h4F, "dec1234_d3");

        // Overflow and recovery
        dec_send(16'd10000, "dec10000");
        chk("ovf_set", 32'(ovf[2]), 32'd1);
        expect_digit(2, 0, 7'h7E, "ovf_d0");
        expect_digit(2, 3, 7'h7E, "ovf_d3");
        dec_send(16'd7, "dec7");
        chk("ovf_clear", 32'(ovf[2]), 32'd0);
        expect_digit(2, 0, 7'h0F, "dec7_d0");
        expect_digit(2, 1, 7'h7F, "dec7_d1");

        // Reset during conversion abandons it; first edge after reset accepts
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_value = 16'd9999;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_ready", 32'(rdy[2]), 32'd1);
        chk("post_rst_ovf", 32'(ovf[2]), 32'd0);
        d_valid = 1'b1;
        d_value = 16'd5;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        chk("post_rst_accept", 32'(rdy[2]), 32'd0);
        expect_digit(2, 0, 7'h01, "abandon_d0");
        expect_digit(2, 1, 7'h7F, "abandon_d1");
        seen_high = 1'b0;
        for (int i = 0; i < 40 && !seen_high; i++) begin
            @(posedge clk);
            #1;
            if (rdy[2] === 1'b1) seen_high = 1'b1;
        end
        chk("dec5_ready", 32'(seen_high), 32'd1);
        expect_digit(2, 0, 7'h24, "dec5_d0");

        repeat (4) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
